// File: rtl/oldland_bus_arbiter_if.sv
// Signal bundle around the oldland bus arbiter: the CPU fetch port (i_*),
// the CPU data port (d_*) and the shared memory bus (m_*).
// The 'master' modport is the arbiter's view. It takes requests from the CPU
// ports and drives the memory bus as its master. The 'slave' modport is the
// environment's view: the CPU requesters plus the memory/peripheral slave.
// Handshake: a requester raises *_access and holds it, together with its
// address and attributes, until exactly one of *_ack or *_error has pulsed
// for one cycle. On the memory side m_access stays high with m_* stable until
// the slave answers with m_ack and/or m_error, or until the arbiter times out.
interface oldland_bus_arbiter_if;
  logic        i_access;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack;
  logic        i_error;

  logic        d_access;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic [31:0] d_data;
  logic        d_ack;
  logic        d_error;

  logic        m_access;
  logic [31:0] m_addr;
  logic [3:0]  m_bytesel;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [31:0] m_data;
  logic        m_ack;
  logic        m_error;

  modport master (
    input  i_access, i_addr,
    output i_data, i_ack, i_error,
    input  d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
    output d_data, d_ack, d_error,
    output m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    input  m_data, m_ack, m_error
  );

  modport slave (
    output i_access, i_addr,
    input  i_data, i_ack, i_error,
    output d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
    input  d_data, d_ack, d_error,
    input  m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    output m_data, m_ack, m_error
  );
endinterface

// File: rtl/oldland_bus_arbiter.sv
// Shares one memory bus between the CPU instruction-fetch and data ports.
// Grant is registered. Under contention the port that did not win last time
// is granted. Each bus transaction is bounded by a cycle timeout that turns
// into an error pulse on the owning port.
module oldland_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255, // 0 disables the timeout
  parameter int unsigned TO_WIDTH       = 8    // must be able to hold TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oldland_bus_arbiter_if.master bus,
  output logic [1:0]            bus_owner,  // 00 none, 01 fetch, 10 data
  output logic [1:0]            dbg_state   // current FSM state encoding
);

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                  TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant_data; // 0: fetch won last, 1: data won last
  logic [TO_WIDTH-1:0] to_cnt;

  logic                grant_data;
  logic [TO_WIDTH-1:0] to_next;
  logic                to_hit;
  logic                fail_now;

  // Arbitration decision and timeout detection for the current cycle.
  always_comb begin
    grant_data = bus.d_access && (!bus.i_access || !last_grant_data);
    to_next    = to_cnt + TO_WIDTH'(1);
    to_hit     = TO_EN && (to_next == TO_LIMIT);
    // A slave error wins over an ack; a timeout only counts if nobody answered.
    fail_now   = bus.m_error || (!bus.m_ack && to_hit);
  end

  assign dbg_state = state;

  // Arbiter FSM: IDLE grants, BUS waits for the slave, RESP pulses the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      last_grant_data <= 1'b0;
      to_cnt          <= '0;
      bus_owner       <= OWN_NONE;
      bus.m_access    <= 1'b0;
      bus.m_addr      <= '0;
      bus.m_bytesel   <= '0;
      bus.m_wr_en     <= 1'b0;
      bus.m_wr_val    <= '0;
      bus.i_data      <= '0;
      bus.i_ack       <= 1'b0;
      bus.i_error     <= 1'b0;
      bus.d_data      <= '0;
      bus.d_ack       <= 1'b0;
      bus.d_error     <= 1'b0;
    end else begin
      // Completion signals are single-cycle pulses.
      bus.i_ack   <= 1'b0;
      bus.i_error <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.d_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.i_access || bus.d_access) begin
            state           <= ST_BUS;
            to_cnt          <= '0;
            bus.m_access    <= 1'b1;
            last_grant_data <= grant_data;
            if (grant_data) begin
              bus_owner     <= OWN_DATA;
              bus.m_addr    <= bus.d_addr;
              bus.m_bytesel <= bus.d_bytesel;
              bus.m_wr_en   <= bus.d_wr_en;
              bus.m_wr_val  <= bus.d_wr_val;
            end else begin
              // Fetches are always full-word reads.
              bus_owner     <= OWN_FETCH;
              bus.m_addr    <= bus.i_addr;
              bus.m_bytesel <= 4'hf;
              bus.m_wr_en   <= 1'b0;
              bus.m_wr_val  <= '0;
            end
          end
        end

        ST_BUS: begin
          to_cnt <= to_next;
          if (bus.m_error || bus.m_ack || to_hit) begin
            state        <= ST_RESP;
            bus.m_access <= 1'b0;
            bus_owner    <= OWN_NONE;
          end
          if (fail_now) begin
            if (bus_owner == OWN_DATA) bus.d_error <= 1'b1;
            else                       bus.i_error <= 1'b1;
          end else if (bus.m_ack) begin
            if (bus_owner == OWN_DATA) begin
              bus.d_ack  <= 1'b1;
              bus.d_data <= bus.m_data;
            end else begin
              bus.i_ack  <= 1'b1;
              bus.i_data <= bus.m_data;
            end
          end
        end

        // The requester drops or renews its access on the edge leaving RESP,
        // so no arbitration happens here.
        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Bench for oldland_bus_arbiter: directed vector table, hand-written
// contention / timeout / reset sequences, and randomized rounds checked
// against a transaction-level model of the arbitration rules.
module tb_oldland_bus_arbiter;

  localparam int TO  = 8;  // main instance timeout
  localparam int TO4 = 4;  // second instance for the short-timeout case

  logic clk;
  logic rst_n;
  logic [1:0] bus_owner, dbg_state, bus_owner4, dbg_state4;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic        last_grant_d;
  logic [31:0] exp_i_data, exp_d_data;
  logic [31:0] exp_q[$];

  oldland_bus_arbiter_if bus ();
  oldland_bus_arbiter_if bus4 ();

  oldland_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_owner(bus_owner), .dbg_state(dbg_state)
  );

  oldland_bus_arbiter #(.TIMEOUT_CYCLES(TO4), .TO_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .bus_owner(bus_owner4), .dbg_state(dbg_state4)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        port_d;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wval;
    int          dly;
    int          resp;   // bit0 = m_ack, bit1 = m_error, 0 = never answer
    logic [31:0] rdata;
    logic        exp_ack;
    logic        exp_err;
    int          exp_hold;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_access = 0; bus.i_addr = 0;
    bus.d_access = 0; bus.d_addr = 0; bus.d_bytesel = 0; bus.d_wr_en = 0; bus.d_wr_val = 0;
    bus.m_data = 0; bus.m_ack = 0; bus.m_error = 0;
    bus4.i_access = 0; bus4.i_addr = 0;
    bus4.d_access = 0; bus4.d_addr = 0; bus4.d_bytesel = 0; bus4.d_wr_en = 0; bus4.d_wr_val = 0;
    bus4.m_data = 0; bus4.m_ack = 0; bus4.m_error = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    last_grant_d = 0;
    exp_i_data = 0;
    exp_d_data = 0;
  endtask

  task automatic drive_req(input logic port_d, input logic [31:0] addr, input logic [3:0] bsel,
                           input logic wr, input logic [31:0] wval);
    if (port_d) begin
      bus.d_access = 1; bus.d_addr = addr; bus.d_bytesel = bsel;
      bus.d_wr_en = wr; bus.d_wr_val = wval;
    end else begin
      bus.i_access = 1; bus.i_addr = addr;
    end
  endtask

  // Advance one idle cycle and check that no completion pulse lingers.
  task automatic check_idle(input string tag);
    @(negedge clk);
    bus.m_ack = 0; bus.m_error = 0;
    check({tag, " pulses_clear"}, {bus.i_ack, bus.i_error, bus.d_ack, bus.d_error}, 4'b0000);
    check({tag, " m_access_idle"}, bus.m_access, 1'b0);
  endtask

  // Act as slave for one granted transaction and check the whole exchange.
  // Returns at the negedge of the response cycle with the request dropped.
  task automatic serve(input string tag, input logic port_d, input logic [31:0] addr,
                       input logic [3:0] bsel, input logic wr, input logic [31:0] wval,
                       input int dly, input int resp, input logic [31:0] rdata, input int exp_wait,
                       input logic exp_ack, input logic exp_err, input int exp_hold,
                       input logic [31:0] exp_data);
    int  waited = 0;
    int  hold = 0;
    int  j = 0;
    bit  got = 0;
    logic [3:0] exp_pulse;
    while (!got && waited < 20) begin
      @(negedge clk);
      bus.m_ack = 0; bus.m_error = 0;
      waited++;
      if (bus.m_access) got = 1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s grant_wait: no m_access within 20 cycles, expected after %0d", tag, exp_wait);
      if (port_d) bus.d_access = 0; else bus.i_access = 0;
      return;
    end
    check({tag, " grant_wait"}, waited, exp_wait);
    check({tag, " bus_owner"}, bus_owner, port_d ? 2'b10 : 2'b01);
    check({tag, " m_addr"}, bus.m_addr, addr);
    check({tag, " m_bytesel"}, bus.m_bytesel, bsel);
    check({tag, " m_wr"}, {bus.m_wr_en, bus.m_wr_val}, {wr, wval});
    while (bus.m_access && j < 40) begin
      hold++;
      bus.m_data = $urandom;
      if (j == dly && resp != 0) begin
        bus.m_ack = resp[0];
        bus.m_error = resp[1];
        bus.m_data = rdata;
      end
      @(negedge clk);
      bus.m_ack = 0; bus.m_error = 0;
      j++;
    end
    check({tag, " hold_cycles"}, hold, exp_hold);
    exp_pulse = port_d ? {2'b00, exp_ack, exp_err} : {exp_ack, exp_err, 2'b00};
    check({tag, " pulses"}, {bus.i_ack, bus.i_error, bus.d_ack, bus.d_error}, exp_pulse);
    check({tag, " rdata"}, port_d ? bus.d_data : bus.i_data, exp_data);
    check({tag, " owner_resp"}, bus_owner, 2'b00);
    if (port_d) bus.d_access = 0; else bus.i_access = 0;
    // A late ack arriving after an error must be ignored.
    if (exp_err) bus.m_ack = 1;
  endtask

  // One data-port transaction on the short-timeout instance.
  task automatic serve4(input string tag, input int dly, input int resp, input logic [31:0] rdata,
                        input int exp_hold, input logic exp_ack, input logic exp_err,
                        input logic [31:0] exp_data);
    int hold = 0;
    int j = 0;
    @(negedge clk);
    bus4.m_ack = 0;
    bus4.d_access = 1; bus4.d_addr = 32'h500; bus4.d_bytesel = 4'hf; bus4.d_wr_en = 0;
    @(negedge clk);
    check({tag, " m_access"}, bus4.m_access, 1'b1);
    while (bus4.m_access && j < 40) begin
      hold++;
      if (j == dly && resp != 0) begin
        bus4.m_ack = resp[0]; bus4.m_error = resp[1]; bus4.m_data = rdata;
      end
      @(negedge clk);
      bus4.m_ack = 0; bus4.m_error = 0; bus4.m_data = $urandom;
      j++;
    end
    check({tag, " hold_cycles"}, hold, exp_hold);
    check({tag, " pulses"}, {bus4.d_ack, bus4.d_error}, {exp_ack, exp_err});
    check({tag, " d_data"}, bus4.d_data, exp_data);
    bus4.d_access = 0;
    bus4.m_ack = 1;  // late ack in the response cycle
    @(negedge clk);
    bus4.m_ack = 0;
    check({tag, " after"}, {bus4.d_ack, bus4.d_error, bus4.m_access}, 3'b000);
  endtask

  initial begin
    int          mode;
    logic        first_d, pd;
    logic [31:0] f_addr, d_addr, d_wval, rdata, cur_data;
    logic [3:0]  d_bsel;
    logic        d_wr, e_ack, e_err, timed;
    int          dly, resp, hold;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 4'hf, 32'h0,         0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 4'h3, 32'h0000_1234, 4, 1, 32'h5555_AAAA, 1'b1, 1'b0, 5, 32'h5555_AAAA};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 4'hf, 32'h0,         1, 3, 32'h0000_0077, 1'b0, 1'b1, 2, 32'h5555_AAAA};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 4'hf, 32'h0,         2, 2, 32'h0000_0099, 1'b0, 1'b1, 3, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 4'hf, 32'h0,         0, 0, 32'h0,         1'b0, 1'b1, 8, 32'h5555_AAAA};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0108, 4'hf, 32'h0,         7, 1, 32'h0BAD_F00D, 1'b1, 1'b0, 8, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 4'hc, 32'hA5A5_A5A5, 8, 1, 32'h0000_0001, 1'b0, 1'b1, 8, 32'h5555_AAAA};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0044, 4'h5, 32'h0,         3, 1, 32'h600D_CAFE, 1'b1, 1'b0, 4, 32'h600D_CAFE};

    // Reset block
    rst_n = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset m_bus", {bus.m_access, bus.m_addr, bus.m_bytesel, bus.m_wr_en, bus.m_wr_val}, '0);
    check("reset owner", bus_owner, 2'b00);
    check("reset data", {bus.i_data, bus.d_data}, 64'h0);
    check("reset pulses", {bus.i_ack, bus.i_error, bus.d_ack, bus.d_error}, 4'b0000);
    rst_n = 1;
    last_grant_d = 0; exp_i_data = 0; exp_d_data = 0;

    // Directed vector table, one port at a time
    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      check_idle(tag);
      drive_req(vecs[v].port_d, vecs[v].addr, vecs[v].bsel, vecs[v].wr, vecs[v].wval);
      serve(tag, vecs[v].port_d, vecs[v].addr, vecs[v].port_d ? vecs[v].bsel : 4'hf,
            vecs[v].port_d ? vecs[v].wr : 1'b0, vecs[v].port_d ? vecs[v].wval : 32'h0,
            vecs[v].dly, vecs[v].resp, vecs[v].rdata, 1,
            vecs[v].exp_ack, vecs[v].exp_err, vecs[v].exp_hold, vecs[v].exp_data);
    end

    // Contention right after reset: data first, then strict alternation
    do_reset();
    drive_req(1'b1, 32'h1000, 4'hf, 1'b0, 32'h0);
    drive_req(1'b0, 32'h0200, 4'hf, 1'b0, 32'h0);
    serve("cont0_d", 1'b1, 32'h1000, 4'hf, 1'b0, 32'h0, 0, 1, 32'h1111_1111, 1,
          1'b1, 1'b0, 1, 32'h1111_1111);
    drive_req(1'b1, 32'h1004, 4'h1, 1'b1, 32'hCAFE);
    serve("cont1_i", 1'b0, 32'h0200, 4'hf, 1'b0, 32'h0, 1, 1, 32'h2222_2222, 2,
          1'b1, 1'b0, 2, 32'h2222_2222);
    drive_req(1'b0, 32'h0204, 4'hf, 1'b0, 32'h0);
    serve("cont2_d", 1'b1, 32'h1004, 4'h1, 1'b1, 32'hCAFE, 0, 1, 32'h3333_3333, 2,
          1'b1, 1'b0, 1, 32'h3333_3333);
    serve("cont3_i", 1'b0, 32'h0204, 4'hf, 1'b0, 32'h0, 0, 1, 32'h4444_4444, 2,
          1'b1, 1'b0, 1, 32'h4444_4444);
    exp_i_data = 32'h4444_4444; exp_d_data = 32'h3333_3333; last_grant_d = 0;

    // Short-timeout instance: a good load, then a slave that never answers
    serve4("to4_ok", 0, 1, 32'hCAFE_0001, 1, 1'b1, 1'b0, 32'hCAFE_0001);
    serve4("to4_timeout", 0, 0, 32'h0, TO4, 1'b0, 1'b1, 32'hCAFE_0001);

    // Randomized rounds against the transaction-level model
    for (int r = 0; r < 80; r++) begin
      mode    = $urandom_range(1, 3);  // 1 fetch, 2 data, 3 both
      f_addr  = $urandom;
      d_addr  = $urandom;
      d_bsel  = 4'($urandom_range(0, 15));
      d_wr    = 1'($urandom_range(0, 1));
      d_wval  = $urandom;
      check_idle($sformatf("rnd%0d", r));
      if (mode != 2) drive_req(1'b0, f_addr, 4'hf, 1'b0, 32'h0);
      if (mode != 1) drive_req(1'b1, d_addr, d_bsel, d_wr, d_wval);
      first_d = (mode == 3) ? !last_grant_d : (mode == 2);
      for (int k = 0; k < ((mode == 3) ? 2 : 1); k++) begin
        pd    = (k == 0) ? first_d : !first_d;
        dly   = $urandom_range(0, 9);
        resp  = $urandom_range(0, 3);
        rdata = $urandom;
        timed = (resp == 0) || (dly >= TO);
        hold  = timed ? TO : dly + 1;
        e_ack = !timed && (resp == 1);
        e_err = !e_ack;
        if (e_ack) begin
          if (pd) exp_d_data = rdata; else exp_i_data = rdata;
        end
        cur_data = pd ? exp_d_data : exp_i_data;
        exp_q.push_back(cur_data);
        serve($sformatf("rnd%0d_%s", r, pd ? "d" : "i"), pd,
              pd ? d_addr : f_addr, pd ? d_bsel : 4'hf, pd ? d_wr : 1'b0, pd ? d_wval : 32'h0,
              dly, resp, rdata, (k == 0) ? 1 : 2, e_ack, e_err, hold, exp_q.pop_front());
        last_grant_d = pd;
      end
    end

    // Reset in the middle of a bus cycle abandons it silently
    check_idle("midrst");
    drive_req(1'b1, 32'h6000, 4'hf, 1'b0, 32'h0);
    @(negedge clk);
    check("midrst granted", bus.m_access, 1'b1);
    rst_n = 0;
    @(negedge clk);
    check("midrst m_access", bus.m_access, 1'b0);
    check("midrst owner", bus_owner, 2'b00);
    check("midrst pulses", {bus.i_ack, bus.i_error, bus.d_ack, bus.d_error}, 4'b0000);
    check("midrst data", {bus.i_data, bus.d_data}, 64'h0);
    clear_inputs();
    rst_n = 1;
    last_grant_d = 0; exp_i_data = 0; exp_d_data = 0;
    check_idle("midrst_after");
    drive_req(1'b1, 32'h7000, 4'h2, 1'b1, 32'h55);
    drive_req(1'b0, 32'h0300, 4'hf, 1'b0, 32'h0);
    serve("midrst_cont_d", 1'b1, 32'h7000, 4'h2, 1'b1, 32'h55, 2, 1, 32'h9999_0000, 1,
          1'b1, 1'b0, 3, 32'h9999_0000);
    serve("midrst_cont_i", 1'b0, 32'h0300, 4'hf, 1'b0, 32'h0, 0, 1, 32'h8888_0000, 2,
          1'b1, 1'b0, 1, 32'h8888_0000);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
